buffer_arbiter: RTL

BUFFER_ARBITER -- requirements
Module: buffer_arbiter

---
 rtl/buffer_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/buffer_arbiter.sv
// buffer_arbiter: round-robin arbiter giving NUM_REQ requesters single-word access to a shared buffer
module buffer_arbiter #(
   parameter int NUM_REQ          = 3,
   parameter int ADDRESS_SIZE     = 9,
   parameter int BUFFER_WORD_SIZE = 16,
   parameter int TIMEOUT_CYCLES   = 255
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic [NUM_REQ-1:0]                    req,
   input  logic [NUM_REQ-1:0]                    req_we,
   input  logic [NUM_REQ*ADDRESS_SIZE-1:0]       req_addr,
   input  logic [NUM_REQ*BUFFER_WORD_SIZE-1:0]   req_wdata,
   output logic [NUM_REQ-1:0]                    gnt,
   output logic [NUM_REQ-1:0]                    ack,
   output logic [BUFFER_WORD_SIZE-1:0]           rdata,
   output logic                                  buf_we,
   output logic                                  buf_re,
   output logic [ADDRESS_SIZE-1:0]               buf_address,
   output logic [BUFFER_WORD_SIZE-1:0]           buf_store_in,
   input  logic [BUFFER_WORD_SIZE-1:0]           buf_store_out,
   input  logic                                  buf_done,
   output logic                                  busy,
   output logic                                  timeout_err
);
   localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, RELEASE} state_t;
   state_t                      state_q, state_d;
   logic [IW-1:0]               rr_ptr_q, rr_ptr_d, owner_q, owner_d, sel;
   logic [CW-1:0]               cnt_q, cnt_d;
   logic [NUM_REQ-1:0]          gnt_q, gnt_d, ack_q, ack_d;
   logic [BUFFER_WORD_SIZE-1:0] rdata_q, rdata_d, wdata_q, wdata_d;
   logic [ADDRESS_SIZE-1:0]     addr_q, addr_d;
   logic                        buf_we_q, buf_we_d, buf_re_q, buf_re_d;
   logic                        busy_q, busy_d, terr_q, terr_d;

   assign gnt          = gnt_q;
   assign ack          = ack_q;
   assign rdata        = rdata_q;
   assign buf_we       = buf_we_q;
   assign buf_re       = buf_re_q;
   assign buf_address  = addr_q;
   assign buf_store_in = wdata_q;
   assign busy         = busy_q;
   assign timeout_err  = terr_q;

   // pick the first requesting index at or after rr_ptr; scanning downward leaves the nearest one in sel
   always_comb begin
      sel = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--)
         if (req[IW'((int'(rr_ptr_q) + k) % NUM_REQ)]) sel = IW'((int'(rr_ptr_q) + k) % NUM_REQ);
   end

   // transaction sequencing: grant, strobe, wait for completion or timeout, release
   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      owner_d  = owner_q;
      cnt_d    = cnt_q;
      gnt_d    = gnt_q;
      ack_d    = '0;
      rdata_d  = rdata_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      buf_we_d = buf_we_q;
      buf_re_d = buf_re_q;
      terr_d   = terr_q;
      case (state_q)
         IDLE: if (|req) begin
            owner_d      = sel;
            gnt_d        = '0;
            gnt_d[sel]   = 1'b1;
            addr_d       = req_addr[sel*ADDRESS_SIZE +: ADDRESS_SIZE];
            wdata_d      = req_wdata[sel*BUFFER_WORD_SIZE +: BUFFER_WORD_SIZE];
            buf_we_d     = req_we[sel];
            buf_re_d     = !req_we[sel];
            state_d      = ISSUE;
         end
         ISSUE: begin
            cnt_d   = '0;
            state_d = WAIT_DONE;
         end
         WAIT_DONE: if (buf_done || cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
            rdata_d  = buf_done ? (buf_re_q ? buf_store_out : rdata_q) : '0;
            terr_d   = terr_q | !buf_done;
            ack_d    = gnt_q;
            buf_we_d = 1'b0;
            buf_re_d = 1'b0;
            cnt_d    = '0;
            state_d  = RELEASE;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
         RELEASE: begin
            gnt_d    = '0;
            rr_ptr_d = owner_q == IW'(NUM_REQ - 1) ? '0 : owner_q + IW'(1);
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
      busy_d = state_d != IDLE;
   end

   // state and registered outputs, cleared asynchronously so reset aborts any transaction at once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         rr_ptr_q <= '0;
         owner_q  <= '0;
         cnt_q    <= '0;
         gnt_q    <= '0;
         ack_q    <= '0;
         rdata_q  <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         buf_we_q <= 1'b0;
         buf_re_q <= 1'b0;
         busy_q   <= 1'b0;
         terr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         owner_q  <= owner_d;
         cnt_q    <= cnt_d;
         gnt_q    <= gnt_d;
         ack_q    <= ack_d;
         rdata_q  <= rdata_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         buf_we_q <= buf_we_d;
         buf_re_q <= buf_re_d;
         busy_q   <= busy_d;
         terr_q   <= terr_d;
      end
   end
endmodule
